// File: rtl/stage_execute.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// stage_execute
//
// Execute stage sitting between decode and stage_mem. Computes the ALU
// result, load/store effective address, branch compare and jump link/target.
// It registers everything into the stage_mem pipeline register. It stalls
// decode while stage_mem is stalled or the multiplier is busy, and it
// squashes its output on a redirect from stage_mem.
//
// Build option:
//   EXEC_MUL_EN  when defined, ops 10-13 (MUL/MULH/MULHSU/MULHU) run on an
//                iterative shift-add multiplier retiring MUL_STEP bits per
//                cycle. When undefined, those ops take the 1-cycle path and
//                produce data0 = 0. MUL_STEP exists only in that build.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   ex_valid                  decode presents an instruction
//   ex_pc, ex_op              instruction PC, ALU operation
//   ex_rs1, ex_rs2, ex_imm    register operands, sign-extended immediate
//   ex_use_imm, ex_use_pc     ALU B = imm, ALU A = pc
//   ex_read, ex_write,
//   ex_extend, ex_width       load/store controls (passed through)
//   ex_jmp, ex_br             jump, conditional branch
//   ex_br_cond, ex_br_inv     0 EQ / 1 LT / 2 LTU, invert flag (passed through)
//   ex_wb_reg                 destination register
//   mem_stall                 stage_mem cannot accept
//   flush                     redirect from stage_mem
//   ex_stall                  decode must hold its inputs
//   mem_*, wb_reg             registered inputs of stage_mem
// ---------------------------------------------------------------------------
module stage_execute
`ifdef EXEC_MUL_EN
#(
    parameter int MUL_STEP = 1  // multiplier bits retired per cycle: 1, 2 or 4
)
`endif
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [31:0] ex_imm,
    input  logic        ex_use_imm,
    input  logic        ex_use_pc,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic        ex_extend,
    input  logic [1:0]  ex_width,
    input  logic        ex_jmp,
    input  logic        ex_br,
    input  logic [1:0]  ex_br_cond,
    input  logic        ex_br_inv,
    input  logic [4:0]  ex_wb_reg,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        ex_stall,
    output logic        mem_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_data0,
    output logic [31:0] mem_data1,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_extend,
    output logic [1:0]  mem_width,
    output logic        mem_jmp,
    output logic        mem_br,
    output logic        mem_br_inv,
    output logic [4:0]  wb_reg
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,  OP_SUB   = 4'd1,  OP_SLL    = 4'd2,  OP_SLT   = 4'd3,
        OP_SLTU   = 4'd4,  OP_XOR   = 4'd5,  OP_SRL    = 4'd6,  OP_SRA   = 4'd7,
        OP_OR     = 4'd8,  OP_AND   = 4'd9,  OP_MUL    = 4'd10, OP_MULH  = 4'd11,
        OP_MULHSU = 4'd12, OP_MULHU = 4'd13, OP_PASSB  = 4'd14, OP_RSVD  = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data0;
        logic [31:0] data1;
        logic        read;
        logic        write;
        logic        extend;
        logic [1:0]  width;
        logic        jmp;
        logic        br;
        logic        br_inv;
        logic [4:0]  wb_reg;
    } mem_regs_t;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        br_cmp;
    mem_regs_t   regs_q, regs_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mul_block;   // multiplier owns the stage this cycle: no load
    logic        load_en;

    // ------------------------------------------------------------------
    // Operand select, ALU and branch compare
    // ------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default before
    // any branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        alu_a   = ex_use_pc  ? ex_pc  : ex_rs1;
        alu_b   = ex_use_imm ? ex_imm : ex_rs2;
        alu_res = '0;
        case (ex_op)
            OP_ADD:   alu_res = alu_a + alu_b;
            OP_SUB:   alu_res = alu_a - alu_b;
            OP_SLL:   alu_res = alu_a << alu_b[4:0];
            OP_SLT:   alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU:  alu_res = {31'b0, alu_a < alu_b};
            OP_XOR:   alu_res = alu_a ^ alu_b;
            OP_SRL:   alu_res = alu_a >> alu_b[4:0];
            OP_SRA:   alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            OP_OR:    alu_res = alu_a | alu_b;
            OP_AND:   alu_res = alu_a & alu_b;
            OP_PASSB: alu_res = alu_b;
            // Multiply ops read 0 here; the multiplier, when built, overrides.
            default:  alu_res = '0;
        endcase
    end

    // Raw compare only; stage_mem applies mem_br_inv for NE/GE/GEU.
    always_comb begin
        br_cmp = 1'b0;
        case (ex_br_cond)
            2'd0:    br_cmp = (ex_rs1 == ex_rs2);
            2'd1:    br_cmp = ($signed(ex_rs1) < $signed(ex_rs2));
            2'd2:    br_cmp = (ex_rs1 < ex_rs2);
            default: br_cmp = 1'b0;
        endcase
    end

`ifdef EXEC_MUL_EN
    // ------------------------------------------------------------------
    // Iterative multiplier: magnitudes in, sign applied once at the end
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;

    localparam logic [4:0] MUL_CNT_INIT = 5'(32 / MUL_STEP - 1);

    mul_state_e  state_q, state_d;
    logic [63:0] acc_q, acc_d, acc_step;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        is_mul_op;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod;
    logic [31:0] mul_res;

    // A multiply op carrying jump/branch/memory controls is not a multiply.
    assign is_mul_op = (ex_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU})
                       & ~ex_jmp & ~ex_br & ~ex_read & ~ex_write;

    always_comb begin
        // MUL/MULH: both signed; MULHSU: rs1 signed only; MULHU: unsigned.
        a_neg = (ex_op != OP_MULHU) & alu_a[31];
        b_neg = ((ex_op == OP_MUL) | (ex_op == OP_MULH)) & alu_b[31];
        a_mag = a_neg ? (~alu_a + 32'd1) : alu_a;
        b_mag = b_neg ? (~alu_b + 32'd1) : alu_b;
    end

    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) acc_step = acc_step + (mcand_q << i);
        end
        prod    = neg_q ? (~acc_q + 64'd1) : acc_q;
        mul_res = (ex_op == OP_MUL) ? prod[31:0] : prod[63:32];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        case (state_q)
            MUL_IDLE: begin
                if (ex_valid & is_mul_op & ~mem_stall & ~flush) begin
                    state_d  = MUL_BUSY;
                    acc_d    = '0;
                    mcand_d  = {32'b0, a_mag};
                    mplier_d = b_mag;
                    cnt_d    = MUL_CNT_INIT;
                    neg_d    = a_neg ^ b_neg;
                end
            end
            MUL_BUSY: begin
                if (flush & ~mem_stall) begin
                    state_d = MUL_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << MUL_STEP;
                    mplier_d = mplier_q >> MUL_STEP;
                    cnt_d    = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                // Either the result loads or a flush aborts; both end here.
                if (!mem_stall) state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= MUL_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: the multiplier datapath has no reset; it is always initialised
    // on the IDLE->BUSY transition before anything reads it.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        cnt_q    <= cnt_d;
        neg_q    <= neg_d;
    end

    assign mul_block = (state_q == MUL_BUSY) | ((state_q == MUL_IDLE) & ex_valid & is_mul_op);
    // DONE releases decode for exactly the cycle the result loads.
    assign ex_stall  = mem_stall | mul_block;
`else
    assign mul_block = 1'b0;
    assign ex_stall  = mem_stall;
`endif

    // ------------------------------------------------------------------
    // Result mux into the stage_mem register
    // ------------------------------------------------------------------
    always_comb begin
        regs_d.pc     = ex_pc;
        regs_d.read   = ex_read;
        regs_d.write  = ex_write;
        regs_d.extend = ex_extend;
        regs_d.width  = ex_width;
        regs_d.jmp    = ex_jmp;
        regs_d.br     = ex_br;
        regs_d.br_inv = ex_br_inv;
        regs_d.wb_reg = ex_wb_reg;
        regs_d.data0  = alu_res;
        regs_d.data1  = ex_rs2;
        if (ex_jmp) begin
            regs_d.data0 = ex_pc + 32'd4;
            regs_d.data1 = (alu_a + ex_imm) & ~32'd1;
        end else if (ex_br) begin
            regs_d.data0 = {31'b0, br_cmp};
            regs_d.data1 = ex_pc + ex_imm;
        end else if (ex_read | ex_write) begin
            regs_d.data0 = ex_rs1 + ex_imm;
        end
`ifdef EXEC_MUL_EN
        if (state_q == MUL_DONE) regs_d.data0 = mul_res;
`endif
    end

    // Priority: stall holds everything (flush ignored), flush drops,
    // a multiplier in flight drops, otherwise load.
    assign load_en = ~mem_stall & ~flush & ~mul_block;

    always_comb begin
        mem_valid_d = 1'b0;
        if (mem_stall)    mem_valid_d = mem_valid_q;
        else if (load_en) mem_valid_d = ex_valid;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_valid_q <= 1'b0;
            regs_q      <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            if (load_en) regs_q <= regs_d;
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_pc     = regs_q.pc;
    assign mem_data0  = regs_q.data0;
    assign mem_data1  = regs_q.data1;
    assign mem_read   = regs_q.read;
    assign mem_write  = regs_q.write;
    assign mem_extend = regs_q.extend;
    assign mem_width  = regs_q.width;
    assign mem_jmp    = regs_q.jmp;
    assign mem_br     = regs_q.br;
    assign mem_br_inv = regs_q.br_inv;
    assign wb_reg     = regs_q.wb_reg;

endmodule

// File: tb/tb_stage_execute.sv
`timescale 1ns/1ps
// Testbench for stage_execute: directed vectors, expected responses queued
// at issue and compared by an independent monitor when stage_mem consumes.
module tb_stage_execute;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic [3:0]  ex_op;
    logic        ex_use_imm, ex_use_pc, ex_read, ex_write, ex_extend;
    logic [1:0]  ex_width;
    logic        ex_jmp, ex_br, ex_br_inv;
    logic [1:0]  ex_br_cond;
    logic [4:0]  ex_wb_reg;
    logic        mem_stall, flush;
    logic        ex_stall, mem_valid;
    logic [31:0] mem_pc, mem_data0, mem_data1;
    logic        mem_read, mem_write, mem_extend, mem_jmp, mem_br, mem_br_inv;
    logic [1:0]  mem_width;
    logic [4:0]  wb_reg;

    always #5 clk = ~clk;

    stage_execute dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_op(ex_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_use_imm(ex_use_imm), .ex_use_pc(ex_use_pc), .ex_read(ex_read),
        .ex_write(ex_write), .ex_extend(ex_extend), .ex_width(ex_width),
        .ex_jmp(ex_jmp), .ex_br(ex_br), .ex_br_cond(ex_br_cond),
        .ex_br_inv(ex_br_inv), .ex_wb_reg(ex_wb_reg), .mem_stall(mem_stall),
        .flush(flush), .ex_stall(ex_stall), .mem_valid(mem_valid),
        .mem_pc(mem_pc), .mem_data0(mem_data0), .mem_data1(mem_data1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_extend(mem_extend),
        .mem_width(mem_width), .mem_jmp(mem_jmp), .mem_br(mem_br),
        .mem_br_inv(mem_br_inv), .wb_reg(wb_reg)
    );

    typedef struct packed {
        logic [31:0] pc, rs1, rs2, imm;
        logic [3:0]  op;
        logic        use_imm, use_pc, rd, wr, ext;
        logic [1:0]  width;
        logic        jmp, br;
        logic [1:0]  cond;
        logic        inv;
        logic [4:0]  wb;
        logic [31:0] d0, d1;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc, d0, d1;
        logic [12:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic vec_t alu(input logic [3:0] op, input logic [31:0] a, b, d0);
        vec_t v = '0;
        v.op = op; v.rs1 = a; v.rs2 = b; v.pc = 32'h200; v.wb = 5'd5;
        v.d0 = d0; v.d1 = b;
        return v;
    endfunction

    function automatic vec_t br(input logic [1:0] cond, input logic inv,
                                input logic [31:0] a, b, pc, imm, d0);
        vec_t v = '0;
        v.br = 1'b1; v.cond = cond; v.inv = inv; v.rs1 = a; v.rs2 = b;
        v.pc = pc; v.imm = imm; v.d0 = d0; v.d1 = pc + imm;
        return v;
    endfunction

    function automatic vec_t jmp(input logic use_pc, input logic [31:0] a, pc, imm, d1);
        vec_t v = '0;
        v.jmp = 1'b1; v.use_pc = use_pc; v.rs1 = a; v.pc = pc; v.imm = imm;
        v.wb = 5'd1; v.d0 = pc + 32'd4; v.d1 = d1;
        return v;
    endfunction

    task automatic present(input vec_t v);
        ex_valid = 1'b1; ex_pc = v.pc; ex_op = v.op; ex_rs1 = v.rs1;
        ex_rs2 = v.rs2; ex_imm = v.imm; ex_use_imm = v.use_imm;
        ex_use_pc = v.use_pc; ex_read = v.rd; ex_write = v.wr;
        ex_extend = v.ext; ex_width = v.width; ex_jmp = v.jmp; ex_br = v.br;
        ex_br_cond = v.cond; ex_br_inv = v.inv; ex_wb_reg = v.wb;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.pc = v.pc; e.d0 = v.d0; e.d1 = v.d1;
        e.ctrl = {v.rd, v.wr, v.ext, v.width, v.jmp, v.br, v.inv, v.wb};
        sb.push_back(e);
    endtask

    // Present, queue the expectation, wait (bounded) until accepted.
    task automatic drive(input vec_t v, output int stalls);
        present(v);
        push_exp(v);
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!ex_stall) break;
            stalls++;
        end
        if (stalls >= 200) begin
            n_checks++;
            $display("FAIL drive_timeout: ex_stall high for %0d cycles, required low", stalls);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    // Monitor: an output counts when stage_mem takes it (valid, no stall).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && mem_valid && !mem_stall) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got data0 0x%0h, required no output", mem_data0);
                end else begin
                    e = sb.pop_front();
                    check("data0", {32'b0, mem_data0}, {32'b0, e.d0});
                    check("data1", {32'b0, mem_data1}, {32'b0, e.d1});
                    check("pc_ctrl",
                          {19'b0, mem_pc, mem_read, mem_write, mem_extend, mem_width,
                           mem_jmp, mem_br, mem_br_inv, wb_reg},
                          {19'b0, e.pc, e.ctrl});
                end
            end
        end
    end

    initial begin
        int   st;
        vec_t v;

        reset_n = 1'b0; mem_stall = 1'b0; flush = 1'b0;
        present('0);
        ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {mem_valid, mem_data0, mem_pc}, 65'd0);
        mem_stall = 1'b1; #1;
        check("reset_stall_follows", ex_stall, 1);
        mem_stall = 1'b0; #1;
        check("reset_stall_clear", ex_stall, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ALU patterns
        drive(alu(4'd0,  32'd5,        32'd7,        32'd12),       st);
        drive(alu(4'd1,  32'd5,        32'd7,        32'hFFFFFFFE), st);
        drive(alu(4'd7,  32'h80000000, 32'd4,        32'hF8000000), st);
        drive(alu(4'd6,  32'h80000000, 32'd4,        32'h08000000), st);
        drive(alu(4'd2,  32'd1,        32'h21,       32'd2),        st);
        drive(alu(4'd3,  32'hFFFFFFFF, 32'd1,        32'd1),        st);
        drive(alu(4'd4,  32'd1,        32'hFFFFFFFF, 32'd1),        st);
        drive(alu(4'd4,  32'hFFFFFFFF, 32'd1,        32'd0),        st);
        drive(alu(4'd5,  32'hF0F0,     32'hFF00,     32'h0FF0),     st);
        drive(alu(4'd8,  32'hF0F0,     32'hFF00,     32'hFFF0),     st);
        drive(alu(4'd9,  32'hF0F0,     32'hFF00,     32'hF000),     st);
        drive(alu(4'd15, 32'h1234,     32'h5678,     32'd0),        st);
        // LUI (PASSB of imm) and AUIPC (pc + imm)
        v = alu(4'd14, 32'h1, 32'h2, 32'h12345000); v.use_imm = 1'b1; v.imm = 32'h12345000;
        drive(v, st);
        v = alu(4'd0, 32'h1, 32'h2, 32'h110); v.use_imm = 1'b1; v.use_pc = 1'b1;
        v.pc = 32'h100; v.imm = 32'h10;
        drive(v, st);
        // Load / store address
        v = alu(4'd0, 32'h1000, 32'h55, 32'hFFC); v.imm = 32'hFFFFFFFC;
        v.rd = 1'b1; v.ext = 1'b1; v.width = 2'd2;
        drive(v, st);
        v = alu(4'd0, 32'h2000, 32'hDEAD, 32'h2008); v.imm = 32'd8; v.wr = 1'b1; v.width = 2'd1;
        drive(v, st);
        // Branches and jumps
        drive(br(2'd0, 1'b0, 32'd3, 32'd3, 32'h100, 32'h20, 32'd1),                 st);
        drive(br(2'd0, 1'b1, 32'd3, 32'd3, 32'h100, 32'h20, 32'd1),                 st);
        drive(br(2'd1, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h80, 32'hFFFFFFF0, 32'd1),     st);
        drive(br(2'd2, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h80, 32'hFFFFFFF0, 32'd0),     st);
        drive(jmp(1'b0, 32'h1003, 32'h40, 32'd4,   32'h1006), st);
        drive(jmp(1'b1, 32'h0,    32'h40, 32'h100, 32'h140),  st);

        // mem_stall for 3 cycles with a new instruction waiting
        drive(alu(4'd0, 32'd5, 32'd7, 32'd12), st);
        mem_stall = 1'b1;
        v = alu(4'd5, 32'hAAAA, 32'h5555, 32'hFFFF);
        present(v);
        push_exp(v);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ex_stall", ex_stall, 1);
            check("stall_hold", {mem_valid, mem_data0}, {1'b1, 32'd12});
            @(posedge clk); #1;
        end
        mem_stall = 1'b0;
        @(negedge clk);
        check("release_ex_stall", ex_stall, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0;

        // flush without stall drops the incoming instruction
        drive(alu(4'd0, 32'd1, 32'd2, 32'd3), st);
        present(alu(4'd0, 32'd9, 32'd9, 32'd18));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0;
        check("flush_drop", mem_valid, 0);

        // flush under stall is ignored: outputs stay
        drive(alu(4'd0, 32'd20, 32'd22, 32'd42), st);
        mem_stall = 1'b1; flush = 1'b1;
        present(alu(4'd0, 32'd9, 32'd9, 32'd18));
        @(posedge clk); #1;
        check("flush_ignored", {mem_valid, mem_data0}, {1'b1, 32'd42});
        flush = 1'b0; ex_valid = 1'b0; mem_stall = 1'b0;

`ifdef EXEC_MUL_EN
        drive(alu(4'd11, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF), st);
        check("mul_stall_cycles", st, 33);
        drive(alu(4'd10, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1), st);
        drive(alu(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE), st);
        // abort mid-BUSY
        present(alu(4'd10, 32'd7, 32'd9, 32'd63));
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; ex_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("mul_abort", {mem_valid, ex_stall}, 0);
`else
        drive(alu(4'd10, 32'd3, 32'd5, 32'd0), st);
        check("mul_off_no_stall", st, 0);
        drive(alu(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0), st);
`endif

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
